// File: rtl/gemm_job_scheduler_pkg.sv
// Shared definitions for the GEMM job scheduler: FSM state encoding,
// default-width job record and a width helper for occupancy counters.
package gemm_pkg;

  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefTagWidth  = 4;

  typedef enum logic [1:0] {
    SchedIdle   = 2'd0,
    SchedLaunch = 2'd1,
    SchedWait   = 2'd2,
    SchedReport = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0] m;
    logic [DefAddrWidth-1:0] k;
    logic [DefAddrWidth-1:0] n;
    logic [DefTagWidth-1:0]  tag;
  } gemm_job_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gemm_job_scheduler_if.sv
// Job intake, accelerator launch/status and completion signals of the scheduler.
// The slave modport is the scheduler's view; master is the surrounding system's.
interface gemm_job_scheduler_if
  import gemm_pkg::*;
#(
  parameter int unsigned AddrWidth  = 16,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned TagWidth   = 4
) ();

  localparam int unsigned CountWidth = count_width(QueueDepth);

  logic                  job_valid_i;
  logic                  job_ready_o;
  logic [AddrWidth-1:0]  job_m_size_i;
  logic [AddrWidth-1:0]  job_k_size_i;
  logic [AddrWidth-1:0]  job_n_size_i;
  logic [TagWidth-1:0]   job_tag_i;

  logic                  gemm_start_o;
  logic [AddrWidth-1:0]  gemm_m_size_o;
  logic [AddrWidth-1:0]  gemm_k_size_o;
  logic [AddrWidth-1:0]  gemm_n_size_o;
  logic                  gemm_busy_i;
  logic                  gemm_done_i;

  logic                  cmpl_valid_o;
  logic                  cmpl_ready_i;
  logic [TagWidth-1:0]   cmpl_tag_o;
  logic                  cmpl_error_o;

  logic [CountWidth-1:0] queue_count_o;
  logic                  idle_o;

  modport slave (
    input  job_valid_i, job_m_size_i, job_k_size_i, job_n_size_i, job_tag_i,
    input  gemm_busy_i, gemm_done_i, cmpl_ready_i,
    output job_ready_o, gemm_start_o, gemm_m_size_o, gemm_k_size_o, gemm_n_size_o,
    output cmpl_valid_o, cmpl_tag_o, cmpl_error_o, queue_count_o, idle_o
  );

  modport master (
    output job_valid_i, job_m_size_i, job_k_size_i, job_n_size_i, job_tag_i,
    output gemm_busy_i, gemm_done_i, cmpl_ready_i,
    input  job_ready_o, gemm_start_o, gemm_m_size_o, gemm_k_size_o, gemm_n_size_o,
    input  cmpl_valid_o, cmpl_tag_o, cmpl_error_o, queue_count_o, idle_o
  );

endinterface

// File: rtl/gemm_job_fifo.sv
// Circular job FIFO with occupancy count; pushes when full and pops when
// empty are dropped, so callers may leave push/pop asserted freely.
module gemm_job_fifo
  import gemm_pkg::*;
#(
  parameter type         job_t      = gemm_job_t,
  parameter int unsigned QueueDepth = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   push,
  input  job_t                                   push_data,
  input  logic                                   pop,
  output job_t                                   pop_data,
  output logic                                   full,
  output logic                                   empty,
  output logic [count_width(QueueDepth)-1:0]     count
);

  localparam int unsigned PtrWidth   = $clog2(QueueDepth);
  localparam int unsigned CountWidth = count_width(QueueDepth);

  job_t                  mem [QueueDepth];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [CountWidth-1:0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage holds payload only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PtrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrWidth'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountWidth'(1);
        2'b01:   count_q <= count_q - CountWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count_q == CountWidth'(QueueDepth));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/gemm_job_scheduler.sv
// Queues GEMM jobs, launches them one at a time on the accelerator and reports
// a tagged completion per job; jobs with any zero dimension are rejected unlaunched.
module gemm_job_scheduler
  import gemm_pkg::*;
#(
  parameter int unsigned AddrWidth  = 16,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned TagWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  gemm_job_scheduler_if.slave  bus
);

  localparam int unsigned CountWidth = count_width(QueueDepth);

  typedef struct packed {
    logic [AddrWidth-1:0] m;
    logic [AddrWidth-1:0] k;
    logic [AddrWidth-1:0] n;
    logic [TagWidth-1:0]  tag;
  } job_t;

  function automatic logic has_zero_size(input job_t j);
    return (j.m == '0) || (j.k == '0) || (j.n == '0);
  endfunction

  job_t                  in_job;
  job_t                  head_job;
  job_t                  act_job;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CountWidth-1:0] fifo_count;
  logic                  pop;

  sched_state_t          state;
  logic                  start_q;
  logic                  cmpl_valid_q;
  logic                  cmpl_error_q;
  logic [TagWidth-1:0]   cmpl_tag_q;

  assign in_job = '{m:   bus.job_m_size_i,
                    k:   bus.job_k_size_i,
                    n:   bus.job_n_size_i,
                    tag: bus.job_tag_i};

  // The FSM only dequeues from Idle, so a pop never coincides with an active job.
  assign pop = (state == SchedIdle) && !fifo_empty;

  gemm_job_fifo #(
    .job_t      (job_t),
    .QueueDepth (QueueDepth)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (bus.job_valid_i),
    .push_data (in_job),
    .pop       (pop),
    .pop_data  (head_job),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Job sequencing; accelerator busy is deliberately not consulted here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= SchedIdle;
      act_job      <= '0;
      start_q      <= 1'b0;
      cmpl_valid_q <= 1'b0;
      cmpl_error_q <= 1'b0;
      cmpl_tag_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        SchedIdle: begin
          if (!fifo_empty) begin
            act_job <= head_job;
            if (has_zero_size(head_job)) begin
              state        <= SchedReport;
              cmpl_valid_q <= 1'b1;
              cmpl_error_q <= 1'b1;
              cmpl_tag_q   <= head_job.tag;
            end else begin
              state   <= SchedLaunch;
              start_q <= 1'b1;
            end
          end
        end
        SchedLaunch: begin
          state <= SchedWait;
        end
        SchedWait: begin
          if (bus.gemm_done_i) begin
            state        <= SchedReport;
            cmpl_valid_q <= 1'b1;
            cmpl_error_q <= 1'b0;
            cmpl_tag_q   <= act_job.tag;
          end
        end
        SchedReport: begin
          if (bus.cmpl_ready_i) begin
            state        <= SchedIdle;
            cmpl_valid_q <= 1'b0;
          end
        end
        default: begin
          state <= SchedIdle;
        end
      endcase
    end
  end

  assign bus.job_ready_o   = !fifo_full;
  assign bus.gemm_start_o  = start_q;
  assign bus.gemm_m_size_o = act_job.m;
  assign bus.gemm_k_size_o = act_job.k;
  assign bus.gemm_n_size_o = act_job.n;
  assign bus.cmpl_valid_o  = cmpl_valid_q;
  assign bus.cmpl_tag_o    = cmpl_tag_q;
  assign bus.cmpl_error_o  = cmpl_error_q;
  assign bus.queue_count_o = fifo_count;
  assign bus.idle_o        = (state == SchedIdle) && fifo_empty && !bus.gemm_busy_i;

endmodule

// File: doc/gemm_job_scheduler.md
GEMM_JOB_SCHEDULER -- requirements
Module: gemm_job_scheduler

Interface
REQ-001 SHALL have parameter AddrWidth, default 16, meaning width of M/K/N size fields.
REQ-002 SHALL have parameter QueueDepth, default 4, meaning job FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TagWidth, default 4, meaning width of the job identifier.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_i  input  1  clock; rst_ni  input  1  async active-low reset.
REQ-005 SHALL have the job input port: job_valid_i  input  1  job offered; job_ready_o  output  1  job accepted when both high.
REQ-006 SHALL have the job payload: job_m_size_i, job_k_size_i, job_n_size_i  input  AddrWidth each  matrix sizes; job_tag_i  input  TagWidth  job id.
REQ-007 SHALL have the accelerator launch port: gemm_start_o  output  1  start pulse; gemm_m_size_o, gemm_k_size_o, gemm_n_size_o  output  AddrWidth each  active job sizes.
REQ-008 SHALL have the accelerator status inputs: gemm_busy_i  input  1  accelerator busy; gemm_done_i  input  1  completion pulse.
REQ-009 SHALL have the completion port: cmpl_valid_o  output  1; cmpl_ready_i  input  1; cmpl_tag_o  output  TagWidth; cmpl_error_o  output  1  job rejected.
REQ-010 SHALL have the status outputs: queue_count_o  output  $clog2(QueueDepth+1)  queued jobs; idle_o  output  1  no queued or active job.

Function
REQ-011 SHALL accept a job on a clock edge where job_valid_i && job_ready_o, pushing {M,K,N,tag} into the FIFO.
REQ-012 SHALL drive job_ready_o = (queue_count_o < QueueDepth), with no same-cycle pop bypass: a full queue stalls even while popping.
REQ-013 SHALL implement FSM states Idle, Launch, Wait and Report.
REQ-014 In Idle with a non-empty queue, SHALL pop the head into the active registers and go to Report with error=1 if any size is zero, else go to Launch.
REQ-015 In Idle with an empty queue, SHALL remain in Idle.
REQ-016 In Launch, SHALL assert gemm_start_o for exactly one cycle, then go to Wait.
REQ-017 In Wait, SHALL go to Report with error=0 on gemm_done_i; gemm_done_i SHALL be ignored in every other state.
REQ-018 In Report, SHALL assert cmpl_valid_o with stable cmpl_tag_o and cmpl_error_o until cmpl_ready_i, then return to Idle.
REQ-019 Latency: a job accepted at edge t into an empty queue with an idle FSM SHALL be popped at t+1 and raise gemm_start_o during cycle t+1..t+2.
REQ-020 gemm_*_size_o SHALL reflect the active registers, held constant from pop until the next pop.
REQ-021 A simultaneous push and pop SHALL leave queue_count_o unchanged and preserve FIFO order.
REQ-022 FIFO pointers SHALL wrap modulo QueueDepth.
REQ-023 idle_o SHALL be high only when the FSM is in Idle, the queue is empty and gemm_busy_i is low.
REQ-024 gemm_busy_i SHALL be status only and SHALL NOT gate transitions.

Reset
REQ-025 On rst_ni low, SHALL asynchronously go to FSM Idle and reset queue count and pointers to 0, dropping queued jobs.
REQ-026 On rst_ni low, SHALL clear the active registers to 0 and drive gemm_start_o=0, cmpl_valid_o=0, cmpl_error_o=0 and cmpl_tag_o=0.
REQ-027 Reset mid-job SHALL discard the active job without issuing a completion.
REQ-028 After reset, job_ready_o SHALL be 1 and idle_o SHALL follow REQ-023.

Structure
REQ-029 gemm_pkg SHALL hold the FSM enum sched_state_t and the struct gemm_job_t {m,k,n,tag}.
REQ-030 The FIFO SHALL be the sub-module gemm_job_fifo, parameterised on the gemm_job_t type and QueueDepth, with push, pop, full, empty and count.

Verification
REQ-031 Single job M=4,K=8,N=16,tag=3 with done returned 20 cycles after start -> one start pulse, sizes stable, cmpl_tag_o=3, error=0.
REQ-032 Five jobs pushed back-to-back with QueueDepth=4 -> job_ready_o low once count=4, then completions emitted in order with tags 0..4.
REQ-033 Job with K=0, tag=7 -> no gemm_start_o and a completion with tag=7, error=1.
REQ-034 cmpl_ready_i held low 10 cycles in Report -> cmpl_valid_o and tag held, next start not issued until the handshake completes.
REQ-035 Stray gemm_done_i in Idle and Launch -> ignored; reset asserted in Wait -> outputs zero, no completion, queue_count_o=0.
